// File: rtl/gcd_requester_if.sv
// Job, core and response signals of the GCD requester.
// slave is the requester's view; master is the surrounding system.
interface gcd_requester_if #(
    parameter int WIDTH = 8,
    parameter int LAT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic [WIDTH-1:0] gcd_y;
    logic             gcd_done;
    logic             gcd_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_error;
    logic             rsp_timeout;
    logic [LAT_W-1:0] rsp_latency;
    logic             busy;

    modport slave (
        input  req_valid, req_a, req_b,
        input  gcd_y, gcd_done, gcd_error,
        input  rsp_ready,
        output req_ready,
        output gcd_start, gcd_a, gcd_b,
        output rsp_valid, rsp_y, rsp_error,
        output rsp_timeout, rsp_latency, busy
    );

    modport master (
        output req_valid, req_a, req_b,
        output gcd_y, gcd_done, gcd_error,
        output rsp_ready,
        input  req_ready,
        input  gcd_start, gcd_a, gcd_b,
        input  rsp_valid, rsp_y, rsp_error,
        input  rsp_timeout, rsp_latency, busy
    );
endinterface

// File: rtl/gcd_requester.sv
// Issues one GCD job at a time to the core and returns
// result, error/timeout flags and START-to-DONE latency.
module gcd_requester #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int LAT_W   = 8
) (
    input logic            clk,
    input logic            rst,
    gcd_requester_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [LAT_W-1:0] TMO = LAT_W'(TIMEOUT);

    state_t           state, state_n;
    logic             start_q, start_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             valid_q, valid_n;
    logic [WIDTH-1:0] y_q, y_n;
    logic             err_q, err_n;
    logic             to_q, to_n;
    logic [LAT_W-1:0] lat_q, lat_n;
    logic             busy_q, busy_n;
    logic             armed, armed_n;
    logic [LAT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            start_q <= start_n;
            a_q     <= a_n;
            b_q     <= b_n;
            valid_q <= valid_n;
            y_q     <= y_n;
            err_q   <= err_n;
            to_q    <= to_n;
            lat_q   <= lat_n;
            busy_q  <= busy_n;
            armed   <= armed_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        y_n     = y_q;
        err_n   = err_q;
        to_n    = to_q;
        lat_n   = lat_q;
        armed_n = armed;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    a_n     = bus.req_a;
                    b_n     = bus.req_b;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A DONE still high from the last job must drop first
                armed_n = ~bus.gcd_done;
                cnt_n   = LAT_W'(1);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.gcd_done) armed_n = 1'b1;
                if (armed && bus.gcd_done) begin
                    y_n     = bus.gcd_y;
                    err_n   = bus.gcd_error;
                    to_n    = 1'b0;
                    lat_n   = cnt;
                    state_n = S_RESP;
                end else if (cnt == TMO) begin
                    y_n     = '0;
                    err_n   = 1'b0;
                    to_n    = 1'b1;
                    lat_n   = TMO;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Registered outputs follow the state being entered
        start_n = (state_n == S_ISSUE);
        valid_n = (state_n == S_RESP);
        busy_n  = (state_n != S_IDLE);
    end

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.gcd_start   = start_q;
    assign bus.gcd_a       = a_q;
    assign bus.gcd_b       = b_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_y       = y_q;
    assign bus.rsp_error   = err_q;
    assign bus.rsp_timeout = to_q;
    assign bus.rsp_latency = lat_q;
    assign bus.busy        = busy_q;
endmodule
